// File: rtl/rv32_ifetch.sv
// rv32_ifetch: instruction fetch unit with a one-entry fetch buffer (B0)
// in front of an instruction memory that accepts one read at a time.
// Optional feature macro IFETCH_PREFETCH_EN adds a second buffer (B1)
// that is filled by a sequential prefetch of the word following B0.
module rv32_ifetch #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    input  logic          flush,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic          misaligned,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TW  = AW - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] reqAddr_q, reqAddr_d;
    logic          discard_q, discard_d;
    logic          b0Valid_q, b0Valid_d;
    logic [TW-1:0] b0Tag_q, b0Tag_d;
    logic [31:0]   b0Data_q, b0Data_d;

    logic [TW-1:0] pcTag;
    logic          aligned;
    logic          b0Hit;
    logic          hit;
    logic          demandMiss;
    logic          startReq;
    logic          fillDone;
    logic          fillWrite;
    logic [AW-1:0] startAddr;

    assign pcTag    = pc[AW-1:2];
    assign aligned  = (pc[1:0] == 2'b00);
    assign b0Hit    = aligned && b0Valid_q && (b0Tag_q == pcTag);
    assign fillDone = (state_q == WAIT) && mem_rvalid;
    // A response is dropped if a flush hit its transaction earlier or lands with it.
    assign fillWrite = fillDone && !discard_q && !flush;

`ifdef IFETCH_PREFETCH_EN
    logic          b1Valid_q, b1Valid_d;
    logic [TW-1:0] b1Tag_q, b1Tag_d;
    logic [31:0]   b1Data_q, b1Data_d;
    logic          toB1_q, toB1_d;
    logic          b1Hit;
    logic          pfStart;
    logic          promote;
    logic [TW-1:0] pfTag;

    assign b1Hit      = aligned && b1Valid_q && (b1Tag_q == pcTag);
    assign hit        = b0Hit || b1Hit;
    assign demandMiss = aligned && !hit;
    assign pfTag      = b0Tag_q + TW'(1);
    assign pfStart    = !demandMiss && !flush && b0Valid_q && !b1Valid_q;
    assign startReq   = (state_q == IDLE) && (demandMiss || pfStart);
    assign startAddr  = demandMiss ? {pcTag, 2'b00} : {pfTag, 2'b00};
    // A demand fill landing in B0 on the same edge takes priority over promotion.
    assign promote    = b1Hit && !b0Hit && !(fillWrite && !toB1_q);
`else
    assign hit        = b0Hit;
    assign demandMiss = aligned && !hit;
    assign startReq   = (state_q == IDLE) && demandMiss;
    assign startAddr  = {pcTag, 2'b00};
`endif

    // State register for the memory request FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one request at a time, never aborted by pc changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startReq)   state_d = REQ;
            REQ:     if (mem_gnt)    state_d = WAIT;
            WAIT:    if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: request handshake plus the combinational hit path.
    always_comb begin
        mem_req     = (state_q == REQ);
        mem_addr    = reqAddr_q;
        misaligned  = !aligned;
        instr_valid = hit;
        instruction = NOP;
        if (b0Hit) begin
            instruction = b0Data_q;
        end
`ifdef IFETCH_PREFETCH_EN
        else if (b1Hit) begin
            instruction = b1Data_q;
        end
`endif
    end

    // Buffer, request address and discard tracking; flush always wins on valid bits.
    always_comb begin
        reqAddr_d = reqAddr_q;
        discard_d = discard_q;
        b0Valid_d = b0Valid_q;
        b0Tag_d   = b0Tag_q;
        b0Data_d  = b0Data_q;
`ifdef IFETCH_PREFETCH_EN
        b1Valid_d = b1Valid_q;
        b1Tag_d   = b1Tag_q;
        b1Data_d  = b1Data_q;
        toB1_d    = toB1_q;
`endif
        if (startReq) begin
            reqAddr_d = startAddr;
`ifdef IFETCH_PREFETCH_EN
            toB1_d    = !demandMiss;
`endif
        end

        if (fillDone) begin
            discard_d = 1'b0;
        end else if (flush && (state_q != IDLE)) begin
            discard_d = 1'b1;
        end

`ifdef IFETCH_PREFETCH_EN
        if (fillWrite && toB1_q) begin
            b1Valid_d = 1'b1;
            b1Tag_d   = reqAddr_q[AW-1:2];
            b1Data_d  = mem_rdata;
        end else if (fillWrite) begin
            b0Valid_d = 1'b1;
            b0Tag_d   = reqAddr_q[AW-1:2];
            b0Data_d  = mem_rdata;
        end else if (promote) begin
            b0Valid_d = 1'b1;
            b0Tag_d   = b1Tag_q;
            b0Data_d  = b1Data_q;
            b1Valid_d = 1'b0;
        end
`else
        if (fillWrite) begin
            b0Valid_d = 1'b1;
            b0Tag_d   = reqAddr_q[AW-1:2];
            b0Data_d  = mem_rdata;
        end
`endif

        if (flush) begin
            b0Valid_d = 1'b0;
`ifdef IFETCH_PREFETCH_EN
            b1Valid_d = 1'b0;
`endif
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqAddr_q <= '0;
            discard_q <= 1'b0;
            b0Valid_q <= 1'b0;
            b0Tag_q   <= '0;
            b0Data_q  <= '0;
`ifdef IFETCH_PREFETCH_EN
            b1Valid_q <= 1'b0;
            b1Tag_q   <= '0;
            b1Data_q  <= '0;
            toB1_q    <= 1'b0;
`endif
        end else begin
            reqAddr_q <= reqAddr_d;
            discard_q <= discard_d;
            b0Valid_q <= b0Valid_d;
            b0Tag_q   <= b0Tag_d;
            b0Data_q  <= b0Data_d;
`ifdef IFETCH_PREFETCH_EN
            b1Valid_q <= b1Valid_d;
            b1Tag_q   <= b1Tag_d;
            b1Data_q  <= b1Data_d;
            toB1_q    <= toB1_d;
`endif
        end
    end

endmodule
